// File: rtl/sync_handshake_multi.sv
// Multi-channel toggle handshake carrying a payload from sCLK to dCLK.
// Optional sticky overrun flags: define SYNC_HANDSHAKE_MULTI_OVERRUN_EN.
module sync_handshake_multi #(
  parameter int   CHANNELS     = 1,
  parameter int   WIDTH        = 8,
  parameter int   STAGES       = 2,
  parameter logic INIT         = 1'b0,
  parameter int   DELAY_RETURN = 0
) (
  input  logic                      sCLK,
  input  logic                      sRST,
  input  logic                      dCLK,
  input  logic                      dRST,
  input  logic [CHANNELS-1:0]       sEN,
  input  logic [CHANNELS*WIDTH-1:0] sDATA,
  output logic [CHANNELS-1:0]       sRDY,
  output logic [CHANNELS-1:0]       dPulse,
  output logic [CHANNELS*WIDTH-1:0] dDATA
`ifdef SYNC_HANDSHAKE_MULTI_OVERRUN_EN
  ,
  output logic [CHANNELS-1:0]       sOVERRUN
`endif
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic             toggle;
    logic [WIDTH-1:0] hold;
    logic [STAGES-1:0] ack_sync;
    logic [STAGES-1:0] req_sync;
    logic             last;
    logic             pulse;
    logic [WIDTH-1:0] data;
    logic             ack;
    logic             accept;

    // Ready when the returned acknowledge has caught up with our toggle.
    assign sRDY[i] = (ack_sync[STAGES-1] == toggle);
    assign accept  = sEN[i] & sRDY[i];

    // Acknowledge tap: last sync stage, or the edge-detect state.
    assign ack = (DELAY_RETURN != 0) ? last : req_sync[STAGES-1];

    assign dPulse[i]                 = pulse;
    assign dDATA[i*WIDTH +: WIDTH]   = data;

    // Source: flip the toggle and freeze the payload on acceptance.
    always_ff @(posedge sCLK) begin
      if (sRST) begin
        toggle <= INIT;
        hold   <= '0;
      end else if (accept) begin
        toggle <= ~toggle;
        hold   <= sDATA[i*WIDTH +: WIDTH];
      end
    end

    // Source: bring the acknowledge back across; reset holds sRDY low.
    always_ff @(posedge sCLK) begin
      if (sRST) begin
        ack_sync <= {STAGES{~INIT}};
      end else begin
        ack_sync <= {ack_sync[STAGES-2:0], ack};
      end
    end

    // Destination: sync toggle, detect change, strobe and load payload.
    always_ff @(posedge dCLK) begin
      if (dRST) begin
        req_sync <= {STAGES{INIT}};
        last     <= INIT;
        pulse    <= 1'b0;
        data     <= '0;
      end else begin
        req_sync <= {req_sync[STAGES-2:0], toggle};
        last     <= req_sync[STAGES-1];
        pulse    <= req_sync[STAGES-1] ^ last;
        if (req_sync[STAGES-1] != last) begin
          data <= hold;
        end
      end
    end

`ifdef SYNC_HANDSHAKE_MULTI_OVERRUN_EN
    logic ovr;

    assign sOVERRUN[i] = ovr;

    // Sticky record of any request made while the channel was busy.
    always_ff @(posedge sCLK) begin
      if (sRST) begin
        ovr <= 1'b0;
      end else if (sEN[i] & ~sRDY[i]) begin
        ovr <= 1'b1;
      end
    end
`endif
  end

endmodule

// File: doc/sync_handshake_multi.md
SYNC_HANDSHAKE_MULTI -- requirements
Module: sync_handshake_multi

Interface
REQ-001 SHALL have parameter CHANNELS, default 1, number of independent handshake channels (legal 1..32).
REQ-002 SHALL have parameter WIDTH, default 8, payload bits per channel (legal 1..64).
REQ-003 SHALL have parameter STAGES, default 2, synchroniser depth in each direction (legal 2..4).
REQ-004 SHALL have parameter INIT, default 1'b0, reset value of toggle and destination synchroniser flops.
REQ-005 SHALL have parameter DELAY_RETURN, default 0; when 1 the acknowledge is taken from the destination last-state flop, not the last sync stage.
REQ-006 SHALL have port sCLK, input, 1, source clock.
REQ-007 SHALL have port sRST, input, 1, source reset, synchronous to sCLK, active-high.
REQ-008 SHALL have port dCLK, input, 1, destination clock.
REQ-009 SHALL have port dRST, input, 1, destination reset, synchronous to dCLK, active-high.
REQ-010 SHALL have port sEN, input, CHANNELS, per-channel send request.
REQ-011 SHALL have port sDATA, input, CHANNELS*WIDTH, payload; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-012 SHALL have port sRDY, output, CHANNELS, channel may accept sEN.
REQ-013 SHALL have port dPulse, output, CHANNELS, one-dCLK delivery strobe.
REQ-014 SHALL have port dDATA, output, CHANNELS*WIDTH, delivered payload, same packing as sDATA.

Function
REQ-015 Each channel SHALL operate independently; no channel's state SHALL affect another's.
REQ-016 On a sCLK edge with sEN[i]=1 and sRDY[i]=1, the channel SHALL invert its toggle and capture its sDATA slice into a source holding register.
REQ-017 sEN[i] with sRDY[i]=0 SHALL NOT change the toggle or the holding register.
REQ-018 The toggle SHALL pass through STAGES dCLK flops; on the dCLK edge where the last stage differs from last-state, dPulse[i] SHALL register 1 for exactly one dCLK cycle and the dDATA slice SHALL load the holding register; last-state SHALL then update.
REQ-019 Latency: dPulse[i] and the new dDATA SHALL be visible after STAGES+1 dCLK edges following the capturing sCLK edge, plus up to one dCLK for phase.
REQ-020 dDATA SHALL hold its value between pulses.
REQ-021 The acknowledge (last sync stage, or last-state if DELAY_RETURN=1) SHALL pass through STAGES sCLK flops; sRDY[i] SHALL equal (last ack stage == toggle), combinationally.
REQ-022 Round trip: sRDY[i] SHALL return high STAGES (+1 if DELAY_RETURN) dCLK plus STAGES sCLK cycles after capture, plus phase uncertainty; no second transfer SHALL be accepted before that.
REQ-023 The holding register SHALL be stable from capture until sRDY[i] returns high, so dDATA is never sampled mid-change.
REQ-024 sEN and sRDY both high on every possible cycle SHALL yield one dPulse per accepted sEN, in order, with no loss or duplication.

Reset
REQ-025 While sRST=1: toggles SHALL be INIT, source ack flops ~INIT (forcing sRDY=0), holding registers 0.
REQ-026 While dRST=1: sync flops and last-state SHALL be INIT, dPulse=0, dDATA=0.
REQ-027 After both resets are released, sRDY SHALL rise STAGES sCLK cycles later with no dPulse generated.
REQ-028 sRST asserted alone mid-transfer MAY produce one spurious dPulse (toggle returns to INIT); sRDY SHALL stay low until that ack settles; no further corruption SHALL occur.

Configuration
REQ-029 With SYNC_HANDSHAKE_MULTI_OVERRUN_EN defined, the block SHALL add output sOVERRUN[CHANNELS]: a sticky flag set on any sCLK edge with sEN[i]=1 and sRDY[i]=0, cleared only by sRST.
REQ-030 Without SYNC_HANDSHAKE_MULTI_OVERRUN_EN, the sOVERRUN port and its logic SHALL be absent; overrun requests SHALL be silently ignored per REQ-017.

Verification
REQ-031 CHANNELS=1, WIDTH=8, STAGES=2, sCLK 10ns, dCLK 7ns: sEN with sDATA=8'hA5 -> one dPulse, dDATA=8'hA5 within 3-4 dCLK; sRDY low until ack returns.
REQ-032 CHANNELS=4: sEN=4'b1010 with distinct payloads in one cycle -> dPulse on channels 1 and 3 only, correct slices; channels 0 and 2 dDATA unchanged.
REQ-033 Back-to-back streaming of 100 random words, sEN=sRDY -> exactly 100 dPulses, data in order, no duplicates; repeat with STAGES=4, DELAY_RETURN=1, slower round trip measured.
REQ-034 sEN held high while sRDY=0 with changing sDATA -> no extra dPulse, dDATA equals first captured value; macro defined -> sOVERRUN[i]=1 until sRST.
REQ-035 Both resets asserted mid-transfer -> dPulse=0, dDATA=0, sRDY=0 during reset; sRDY=1 after STAGES sCLK post-release, no dPulse.
REQ-036 INIT=1: reset then single transfer -> behaviour identical to REQ-031.
